mix_columns_seq: RTL and testbench

//  AES MixColumns / InvMixColumns stage, placed directly downstream of ShiftRows and feeding AddRoundKey.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/gf_mult.sv | 23 ++
 rtl/mix_column_word.sv | 37 +++
 rtl/mix_columns_seq.sv | 81 ++++++++
 tb/tb_mix_columns_seq.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions used by mix_columns_seq and its sub-modules.
//   mc_state_t   : MixColumns sequencer states
//   MC_*_COEF    : first matrix row for MixColumns / InvMixColumns, byte 0 in bits [31:24]
//   col_msb      : MSB bit index of column c in a 128-bit FIPS-197 state
//   byte_msb     : MSB bit index of byte r of column c in a 128-bit state
//   coef_byte    : byte i of a packed 4-byte coefficient row
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam logic [31:0] MC_FWD_COEF = 32'h02030101;
  localparam logic [31:0] MC_INV_COEF = 32'h0E0B0D09;

  function automatic logic [6:0] col_msb(input logic [1:0] c);
    return 7'd127 - {c, 5'd0};
  endfunction

  function automatic logic [6:0] byte_msb(input logic [1:0] c, input logic [1:0] r);
    return 7'd127 - {c, 5'd0} - {2'd0, r, 3'd0};
  endfunction

  function automatic logic [7:0] coef_byte(input logic [31:0] row, input int unsigned i);
    return row[31-8*i -: 8];
  endfunction

endpackage

// File: rtl/gf_mult.sv
// GF(2^8) multiplier, reduction polynomial 0x11B, purely combinational.
//   a, b : operands
//   p    : product a*b
module gf_mult (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] sh;

  always_comb begin
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ 8'h1B) : {sh[6:0], 1'b0};
    end
    p = acc;
  end

endmodule

// File: rtl/mix_column_word.sv
// One AES column through the MixColumns (inv=0) or InvMixColumns (inv=1) matrix.
// Combinational; 16 GF multipliers with the coefficient selected by inv.
//   col_in  : input column, byte 0 in bits [31:24]
//   inv     : 0 = forward matrix, 1 = inverse matrix
//   col_out : transformed column, same byte order
module mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  logic [7:0] prod [4][4];

  // Circulant matrix: row r uses the first row rotated right by r.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar k = 0; k < 4; k++) begin : g_term
      localparam int unsigned CI = (k - r + 4) % 4;
      logic [7:0] coef;
      assign coef = inv ? coef_byte(MC_INV_COEF, CI) : coef_byte(MC_FWD_COEF, CI);
      gf_mult u_mul (
        .a (coef),
        .b (col_in[31-8*k -: 8]),
        .p (prod[r][k])
      );
    end
  end

  always_comb begin
    col_out = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      col_out[31-8*r -: 8] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns: one 128-bit state per handshake,
// one column per clock, result held under valid/ready.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake for in_state / in_inv
//   in_state             : FIPS-197 byte order state (byte 0 = bits [127:120])
//   in_inv               : 0 = MixColumns, 1 = InvMixColumns (sampled at acceptance)
//   out_valid/out_ready  : output handshake for out_state
//   out_state            : transformed state, registered
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int unsigned NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  mc_state_t    state;
  mc_state_t    state_nxt;
  logic [1:0]   col;
  logic [127:0] work;
  logic         inv_q;
  logic         accept;
  logic [31:0]  col_cur;
  logic [31:0]  col_mix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = in_valid ? CALC : IDLE;
      CALC:    state_nxt = (col == 2'(NCOL - 1)) ? DONE : CALC;
      DONE:    state_nxt = out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    out_state = work;
  end

  assign accept = in_valid && (state == IDLE);

  assign col_cur = work[col_msb(col) -: 32];

  mix_column_word u_mcw (
    .col_in  (col_cur),
    .inv     (inv_q),
    .col_out (col_mix)
  );

  // col wraps 3->0 on the last CALC edge, leaving it ready for the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      work  <= '0;
      inv_q <= 1'b0;
    end else if (accept) begin
      col   <= '0;
      work  <= in_state;
      inv_q <= in_inv;
    end else if (state == CALC) begin
      work[col_msb(col) -: 32] <= col_mix;
      col                      <= col + 2'd1;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mix_columns_seq #(.NCOL(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: textbook GF(2^8) multiply and matrix product over bytes.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0] a [16];
    logic [7:0] o [16];
    logic [7:0] coef [4];
    logic [127:0] r;
    if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        o[4*c+rr] = 8'h00;
        for (int k = 0; k < 4; k++) o[4*c+rr] ^= gmul(coef[(k + 4 - rr) % 4], a[4*c+k]);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One full transaction. After acceptance in_inv is flipped and in_state scrambled;
  // during the held DONE phase in_valid is pulsed with a different state.
  task automatic xfer(input logic [127:0] s, input logic inv, input int unsigned hold,
                      output logic [127:0] res);
    int unsigned  lat;
    logic         stable;
    logic [127:0] snap;
    lat = 0;
    while (!in_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    check("ready_before_accept", {127'd0, in_ready}, 128'd1);
    in_state = s;
    in_inv   = inv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_state = ~s;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("latency", 128'(lat), 128'd4);
    res    = out_state;
    snap   = out_state;
    stable = 1'b1;
    for (int unsigned i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_state !== snap || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) check("hold_stable", {127'd0, stable}, 128'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("after_out_hs", {126'd0, out_valid, in_ready}, 128'b01);
    @(posedge clk); #1;
    check("no_extra_out", {127'd0, out_valid}, 128'd0);
  endtask

  logic [127:0] x, y, z, s;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {out_state, 2'b00} | 128'(in_ready) | (128'(out_valid) << 1),
          128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 App.B round 1
    xfer(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 0, y);
    check("fips_b_round1", y, 128'h046681e5e0cb199a48f8d37a2806264c);

    // Known columns in column 0, random remainder checked against the model
    x = rnd128();
    s = {32'hdb135345, x[95:0]};
    xfer(s, 1'b0, 0, y);
    check("col_db135345", {96'd0, y[127:96]}, 128'h8e4da1bc);
    check("col_db_rest", y, mix_ref(s, 1'b0));
    s = {32'hf20a225c, x[95:0]};
    xfer(s, 1'b0, 2, y);
    check("col_f20a225c", {96'd0, y[127:96]}, 128'h9fdc589d);
    xfer({32'h01010101, 32'hc6c6c6c6, x[63:0]}, 1'b0, 0, y);
    check("col_01_unchanged", {96'd0, y[127:96]}, 128'h01010101);
    check("col_c6_unchanged", {96'd0, y[95:64]}, 128'hc6c6c6c6);
    xfer({32'h8e4da1bc, x[95:0]}, 1'b1, 0, y);
    check("inv_col_8e4da1bc", {96'd0, y[127:96]}, 128'hdb135345);

    // Backpressure: output held for 10 cycles with in_valid pulsed
    x = rnd128();
    xfer(x, 1'b1, 10, y);
    check("backpressure_inv", y, mix_ref(x, 1'b1));

    // Reset after E2 aborts the state
    x = rnd128();
    in_state = x; in_inv = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_calc", {out_state, out_valid, in_ready}, 130'b01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_output", {127'd0, out_valid}, 128'd0);
    xfer(x, 1'b0, 1, y);
    check("after_rst_fwd", y, mix_ref(x, 1'b0));

    // Random round trips
    for (int i = 0; i < 200; i++) begin
      x = rnd128();
      xfer(x, 1'b0, $urandom_range(0, 3), y);
      check("rand_fwd", y, mix_ref(x, 1'b0));
      xfer(y, 1'b1, $urandom_range(0, 3), z);
      check("rand_roundtrip", z, x);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
